// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU with pipeline stall generation.
// Optional feature macro: DIV_EARLY_EXIT_EN (skip iteration when b==0 or |a|<|b|).
module div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             div_start,
   input  logic             div_signed,
   input  logic             div_annul,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             div_stall,
   output logic             div_ready,
   output logic [WIDTH-1:0] div_hi,
   output logic [WIDTH-1:0] div_lo
);

   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_next_state;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_rem;
   logic [WIDTH-1:0] r_quo;
   logic [WIDTH-1:0] r_div;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;
   logic             r_neg_q;
   logic             r_neg_r;
   logic             r_b_zero;

   logic             w_accept;
   logic             w_finish;
   logic             w_early;
   logic             w_neg_a;
   logic             w_neg_b;
   logic [WIDTH-1:0] w_abs_a;
   logic [WIDTH-1:0] w_abs_b;
   logic [WIDTH:0]   w_shift;
   logic             w_ge;
   logic [WIDTH-1:0] w_diff;
   logic [WIDTH-1:0] w_rem_nx;
   logic [WIDTH-1:0] w_quo_nx;
   logic [WIDTH-1:0] w_lo_fix;
   logic [WIDTH-1:0] w_hi_fix;

   assign w_neg_a = div_signed & a[WIDTH-1];
   assign w_neg_b = div_signed & b[WIDTH-1];
   assign w_abs_a = w_neg_a ? (~a + 1'b1) : a;
   assign w_abs_b = w_neg_b ? (~b + 1'b1) : b;

`ifdef DIV_EARLY_EXIT_EN
   assign w_early = (b == '0) || (w_abs_a < w_abs_b);
`else
   assign w_early = 1'b0;
`endif

   // The remainder register sits above the dividend/quotient register; the
   // compare is one bit wider so a shifted-out MSB is never lost.
   assign w_shift  = {r_rem, r_quo[WIDTH-1]};
   assign w_ge     = (w_shift >= {1'b0, r_div});
   assign w_diff   = w_shift[WIDTH-1:0] - r_div;
   assign w_rem_nx = w_ge ? w_diff : w_shift[WIDTH-1:0];
   assign w_quo_nx = {r_quo[WIDTH-2:0], w_ge};

   // Divide by zero bypasses sign fix-up: quotient all ones, remainder = dividend.
   assign w_lo_fix = r_b_zero ? '1  : (r_neg_q ? (~w_quo_nx + 1'b1) : w_quo_nx);
   assign w_hi_fix = r_b_zero ? r_a : (r_neg_r ? (~w_rem_nx + 1'b1) : w_rem_nx);

   always_comb begin
      w_next_state = r_state;
      w_accept     = 1'b0;
      w_finish     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (div_start && !div_annul) begin
               w_accept     = 1'b1;
               w_next_state = w_early ? S_DONE : S_BUSY;
            end
         end
         S_BUSY: begin
            if (div_annul) begin
               w_next_state = S_IDLE;
            end else if (r_cnt == CW'(1)) begin
               w_finish     = 1'b1;
               w_next_state = S_DONE;
            end
         end
         S_DONE:  w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_cnt    <= '0;
         r_rem    <= '0;
         r_quo    <= '0;
         r_div    <= '0;
         r_a      <= '0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_b_zero <= 1'b0;
         r_hi     <= '0;
         r_lo     <= '0;
      end else if (w_accept) begin
         r_cnt    <= CW'(WIDTH);
         r_rem    <= '0;
         r_quo    <= w_abs_a;
         r_div    <= w_abs_b;
         r_a      <= a;
         r_neg_q  <= w_neg_a ^ w_neg_b;
         r_neg_r  <= w_neg_a;
         r_b_zero <= (b == '0);
         if (w_early) begin
            r_lo <= (b == '0) ? '1 : '0;
            r_hi <= a;
         end
      end else if (r_state == S_BUSY && !div_annul) begin
         r_rem <= w_rem_nx;
         r_quo <= w_quo_nx;
         r_cnt <= r_cnt - CW'(1);
         if (w_finish) begin
            r_lo <= w_lo_fix;
            r_hi <= w_hi_fix;
         end
      end
   end

   assign div_stall = ((r_state == S_IDLE && div_start) || r_state == S_BUSY) && !div_annul;
   assign div_ready = (r_state == S_DONE);
   assign div_hi    = r_hi;
   assign div_lo    = r_lo;

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle 32-bit integer divider in the Execute stage; executes DIV/DIVU and writes results to the HI/LO path.
- Produces `div_stall`, which the hazard unit consumes to freeze the F/D/E/M/W stages while a division is in flight.
- Radix-2 restoring algorithm, one quotient bit per cycle, operating on operand magnitudes with a final sign fix-up.

Parameters:
- WIDTH, 32, operand/result width in bits; the iteration counter is $clog2(WIDTH)+1 bits.

Ports:
- clk  input  1  pipeline clock, all state on rising edge.
- resetn  input  1  synchronous, active-low reset.
- div_start  input  1  E-stage instruction is DIV/DIVU; held high by the pipeline while stalled.
- div_signed  input  1  1 = DIV (signed), 0 = DIVU; sampled with the operands.
- div_annul  input  1  E-stage flush (exception/eret); aborts any operation in progress.
- a  input  WIDTH  dividend (rs), forwarded value.
- b  input  WIDTH  divisor (rt), forwarded value.
- div_stall  output  1  to hazard unit; combinational.
- div_ready  output  1  result valid this cycle.
- div_hi  output  WIDTH  remainder, registered.
- div_lo  output  WIDTH  quotient, registered.

Behaviour:
- Reset (resetn=0 at clk edge): state=IDLE, counter=0, div_hi=0, div_lo=0. div_ready=0 and div_stall=0 follow from IDLE. Reset mid-operation discards it; no result is produced.
- States: IDLE, BUSY, DONE.
- IDLE:
  - div_start=1 and div_annul=0 -> latch a, b, div_signed; compute |a|, |b|; record quotient sign (a[W-1]^b[W-1], signed only) and remainder sign (a[W-1], signed only); clear partial remainder; counter=WIDTH; go to BUSY.
- BUSY, each cycle:
  - Shift {rem, quo} left by 1.
  - Trial-subtract |b| from rem, WIDTH+1 bits wide.
  - If non-negative, keep the difference and set quo LSB=1; otherwise restore.
  - Decrement counter; when counter reaches 1 on this edge, the final bit is done -> DONE.
- Entering DONE: apply sign fix-up (two's-complement negate quo/rem per recorded signs) and register into div_lo/div_hi.
- DONE lasts exactly 1 cycle, then IDLE unconditionally. div_start is still high in DONE because it is the same instruction; it is NOT re-accepted.
- Output decode:
  - div_stall = ((state==IDLE && div_start) || state==BUSY) && !div_annul.
  - div_ready = (state==DONE).
- Latency: the acceptance cycle plus WIDTH BUSY cycles gives WIDTH+1 = 33 stall cycles. div_ready rises in the cycle after the last stall cycle, with div_stall=0, so the pipeline advances and the HI/LO write takes the result.
- div_hi/div_lo hold their value until the next DONE entry.
- Divide by zero (b==0), both signedness modes: div_lo = all ones, div_hi = a (original dividend, no sign fix-up). Full latency is still taken.
- Signed overflow (a=0x80000000, b=0xFFFFFFFF): div_lo=0x80000000, div_hi=0, as produced naturally by the magnitude algorithm plus fix-up.
- div_annul=1 in any state: div_stall=0 combinationally; next state=IDLE; div_hi/div_lo unchanged; div_ready is not asserted for the annulled operation.
- div_annul has priority over div_start in the same cycle.
- Operand changes on a/b after acceptance are ignored.

Optional Feature:
- DIV_EARLY_EXIT_EN defined: in IDLE on acceptance, if b==0 or |a|<|b| (unsigned magnitude compare), go directly to DONE instead of BUSY.
  - Loaded results: |a|<|b| gives div_lo=0, div_hi=a; b==0 gives the divide-by-zero values above.
  - div_stall is high for exactly 1 cycle.
- Undefined: every division takes the full WIDTH+1 stall cycles.

Test Plan:
- DIVU a=100, b=7, start held while stalled -> div_stall high exactly 33 cycles; then div_ready=1 for 1 cycle with div_lo=14, div_hi=2; start still high in DONE is not re-accepted.
- DIV a=0xFFFFFFF9 (-7), b=2 -> div_lo=0xFFFFFFFD (-3), div_hi=0xFFFFFFFF (-1). DIV a=7, b=0xFFFFFFFE (-2) -> div_lo=0xFFFFFFFD, div_hi=1.
- DIV a=0x80000000, b=0xFFFFFFFF -> div_lo=0x80000000, div_hi=0. DIVU a=5, b=0 -> div_lo=0xFFFFFFFF, div_hi=5, still 33 stall cycles (macro off).
- Annul at BUSY cycle 10 -> div_stall=0 in that cycle; IDLE next edge; div_ready never asserted; prior div_hi/div_lo retained; a new DIVU 9/3 started next cycle gives lo=3, hi=0.
- resetn=0 for 1 cycle at BUSY cycle 20 -> outputs 0, state IDLE; a subsequent DIVU 50/5 gives lo=10, hi=0 after 33 stall cycles.
- With DIV_EARLY_EXIT_EN: DIVU 3/10 -> 1 stall cycle, then div_lo=0, div_hi=3. Back-to-back DIVU 100/7 runs at full latency with the correct result.
